// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word-address width, fetch FSM encoding and
// the reset/NOP defaults used by the fetch stage and the IF/ID register.
package cpu_pkg;

    localparam int ADDR_W = 30;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 30'h0000_0000;
    localparam logic [31:0]       NOP_INS_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_pc_sel.sv
// Next-PC selection: a taken branch beats a jump (the branch is the older
// instruction), then sequential advance, otherwise the PC holds.
module if_pc_sel
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic              Branch_ok,
    input  logic              id_Jump,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              consume,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        if (Branch_ok) begin
            next_pc = branch_target;
        end else if (id_Jump) begin
            next_pc = jump_target;
        end else if (consume) begin
            next_pc = pc + ADDR_W'(1);
        end else begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to a
// variable-latency instruction memory and offers one instruction per cycle to IF/ID.
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0]       NOP_INS  = NOP_INS_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              hazard,
    input  logic              BranchBubble,
    input  logic              Branch_ok,
    input  logic              id_Jump,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_ins,
    output logic [ADDR_W-1:0] PC_plus_4
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] flush_addr_q, flush_addr_d;
    logic [31:0]       ins_buf_q, ins_buf_d;

    logic              stall;
    logic              redirect;
    logic              consume;
    logic              advance;
    logic [ADDR_W-1:0] next_pc;

    assign stall    = hazard | BranchBubble;
    assign redirect = Branch_ok | id_Jump;
    assign consume  = !stall && !redirect;

    // Sequential advance only when an instruction is actually handed to IF/ID;
    // kept outside the FSM block so next_pc never depends on that block's outputs.
    assign advance = consume && (((state_q == REQ) && imem_ack) || (state_q == HOLD));

    if_pc_sel u_pc_sel (
        .pc            (pc_q),
        .Branch_ok     (Branch_ok),
        .id_Jump       (id_Jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .consume       (advance),
        .next_pc       (next_pc)
    );

    assign PC_plus_4 = pc_q + ADDR_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;
        ins_buf_d    = ins_buf_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        if_ins       = NOP_INS;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if_ins = imem_rdata;
                end
                if (redirect) begin
                    pc_d = next_pc;
                    // The request to the old pc is still in flight; remember its
                    // address so it stays stable until the memory answers.
                    if (!imem_ack) begin
                        flush_addr_d = pc_q;
                        state_d      = FLUSH;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        ins_buf_d = imem_rdata;
                        state_d   = HOLD;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end

            HOLD: begin
                if_ins = ins_buf_q;
                if (!stall || redirect) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end

            FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = flush_addr_q;
                pc_d      = next_pc;
                if (imem_ack) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            flush_addr_q <= RESET_PC;
            ins_buf_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            ins_buf_q    <= ins_buf_d;
        end
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC (word address [31:2]) and runs a req/ack handshake to a variable-latency instruction memory.
- Each cycle it presents if_ins and PC_plus_4 for IF/ID to latch; it inserts NOP (32'h0) when no instruction is ready.
- Honours load-use stall, branch-bubble stall, and branch/jump redirects.

Parameters:
RESET_PC, 30'h0000_0000, word address loaded into PC on reset
NOP_INS, 32'h0000_0000, instruction value driven when no valid fetch

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
hazard  in  1  load-use stall from hazard unit; IF/ID holds this cycle
BranchBubble  in  1  branch-bubble stall; IF/ID holds this cycle
Branch_ok  in  1  taken branch resolved; redirect to branch_target
id_Jump  in  1  jump decoded in ID; redirect to jump_target
branch_target  in  30  branch destination word address
jump_target  in  30  jump destination word address
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  30  fetch word address; stable while imem_req high
imem_ack  in  1  memory data valid this cycle (one cycle per request)
imem_rdata  in  32  instruction word, valid with imem_ack
if_ins  out  32  instruction offered to IF/ID
PC_plus_4  out  30  pc+1 (word address) offered to IF/ID

Behaviour:
- Definitions:
  - stall = hazard | BranchBubble.
  - redirect = Branch_ok | id_Jump.
  - Target priority: Branch_ok over id_Jump, because the older instruction wins.
  - consume = !stall & !redirect.
- Reset:
  - pc=RESET_PC, state=IDLE, ins_buf=0, imem_req=0, if_ins=NOP_INS, PC_plus_4=RESET_PC+1.
  - An outstanding request is abandoned; an ack arriving in IDLE is ignored.
- PC_plus_4 = pc+1, mod 2^30; it wraps 30'h3FFFFFFF -> 0. imem_addr = pc, except in FLUSH (see below).
- States:
  - IDLE: imem_req=0, if_ins=NOP. Next state REQ unconditionally (one cycle after reset).
  - REQ: imem_req=1. if_ins = imem_ack ? imem_rdata : NOP (combinational pass-through).
    - ack & consume: pc<=pc+1; stay REQ. Gives 1 instr/cycle when ack is tied high.
    - ack & stall & !redirect: ins_buf<=imem_rdata; go to HOLD.
    - ack & redirect: data discarded; pc<=target; stay REQ.
    - !ack & redirect: pc<=target; go to FLUSH.
    - !ack & !redirect: hold.
  - HOLD: imem_req=0, if_ins=ins_buf.
    - consume: pc<=pc+1; go to REQ.
    - redirect: pc<=target; drop ins_buf; go to REQ.
    - stall: remain.
  - FLUSH: imem_req=1, imem_addr=flush_addr (the pre-redirect pc, registered), if_ins=NOP.
    - ack: discard data; go to REQ (pc already holds the target).
    - Further redirects while in FLUSH: update pc only; last one wins.
- Simultaneous events:
  - Redirect overrides stall in every state.
  - Branch_ok & id_Jump together: take branch_target.
- Invariants:
  - imem_req never drops between assertion and ack.
  - imem_addr is constant while req is high.
  - Exactly one ack is accepted per request.
- Latency:
  - Reset release to first imem_req: 1 cycle.
  - Ack to if_ins: 0 cycles (combinational pass-through).
  - Redirect to request at target: next cycle if no request is outstanding.

Decomposition:
- Shared package `cpu_pkg`:
  - state encoding IDLE/REQ/HOLD/FLUSH (2 bits)
  - NOP_INS constant
  - RESET_PC default
  - the 30-bit word-address width constant (also used by if_id)
- One natural combinational sub-module, `if_pc_sel`:
  - Inputs: pc, Branch_ok, id_Jump, branch_target, jump_target, consume.
  - Output: next_pc, using the priority above.
- The FSM, ins_buf and flush_addr stay in if_fetch.

Test Plan:
- Reset high 2 cycles, ack tied 1, rdata=addr-tagged -> first req cycle 1 at 0x0; if_ins follows 0,1,2,… one per cycle; PC_plus_4=pc+1.
- Ack delayed 3 cycles per request -> if_ins=NOP for 3 cycles, then the word; pc advances once per ack; imem_addr stable while req high.
- Ack arrives with hazard=1 for 2 cycles -> HOLD; if_ins=ins_buf both cycles, imem_req=0; pc advances only on the cycle hazard drops.
- Branch_ok with branch_target=0x40 while a request to 0x10 is outstanding (ack 2 cycles later) -> FLUSH keeps addr 0x10 until ack; that data is never driven; next req at 0x40.
- Branch_ok=1 & id_Jump=1 & hazard=1 same cycle, targets 0x80/0xC0 -> next request at 0x80, not stalled.
- pc=30'h3FFFFFFF consumed -> PC_plus_4 was 0 and next imem_addr=0; Reset asserted mid-request -> req=0 next cycle, late ack ignored, restart at RESET_PC.
